// File: rtl/alu_pkg.sv
// alu_pkg: shared funct codes, FSM state enum and shift-width helper for alu_muldiv
package alu_pkg;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic int sw(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/alu_md_iter.sv
// alu_md_iter: W-step unsigned shift-add multiply / restoring divide on magnitudes (ports clk load step tc x y [div when ALU_MULDIV_DIV_EN] -> acc q last; {acc,q} = product, or acc = remainder and q = quotient)
module alu_md_iter import alu_pkg::*; #(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic [sw(W)-1:0]  tc,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  output logic [W-1:0]      acc,
  output logic [W-1:0]      q,
  output logic              last
`ifdef ALU_MULDIV_DIV_EN
  , input logic             div
`endif
);
  logic [W-1:0] m;
  logic [sw(W)-1:0] cnt;
  logic [W:0] add;
  assign add = q[0] ? {1'b0, acc} + {1'b0, m} : {1'b0, acc};
  assign last = cnt == tc;
`ifdef ALU_MULDIV_DIV_EN
  logic [W:0] sh, dif;
  assign sh = {acc, q[W-1]};
  assign dif = sh - {1'b0, m};
`endif
  always_ff @(posedge clk) begin
    if (load) begin
      acc <= '0;
      q <= x;
      m <= y;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
`ifdef ALU_MULDIV_DIV_EN
      if (div) begin
        acc <= dif[W] ? sh[W-1:0] : dif[W-1:0];
        q <= {q[W-2:0], ~dif[W]};
      end else begin
        acc <= add[W:1];
        q <= {add[0], q[W-1:1]};
      end
`else
      acc <= add[W:1];
      q <= {add[0], q[W-1:1]};
`endif
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with registered result, HI/LO and iterative mul/div (ports clk reset start funct a b -> busy done result hi lo; DIV/DIVU enabled by ALU_MULDIV_DIV_EN)
module alu_muldiv import alu_pkg::*; #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   funct,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int SW = sw(W);
  state_t state, nxt;
  logic md_op, accept, load, last, sgn, sa, sb, neg_q;
  logic [W-1:0] alu, xa, yb, acc, q, hi_f, lo_f;
  logic [2*W-1:0] prod;
  assign busy = state != IDLE;
  assign accept = start && !busy;
`ifdef ALU_MULDIV_DIV_EN
  logic is_div, neg_r, dz;
  assign md_op = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign hi_f = is_div ? (neg_r ? -acc : acc) : prod[2*W-1:W];
  assign lo_f = is_div ? (dz ? '1 : neg_q ? -q : q) : prod[W-1:0];
`else
  assign md_op = funct inside {F_MULT, F_MULTU};
  assign hi_f = prod[2*W-1:W];
  assign lo_f = prod[W-1:0];
`endif
  assign load = accept && md_op;
  assign sgn = funct == F_MULT || funct == F_DIV;
  assign sa = sgn && a[W-1];
  assign sb = sgn && b[W-1];
  assign xa = sa ? -a : a;
  assign yb = sb ? -b : b;
  assign prod = neg_q ? -{acc, q} : {acc, q};
  always_comb begin
    nxt = state == IDLE ? (load ? CALC : IDLE) : state == CALC ? (last ? FIX : CALC) : IDLE;
  end
  always_comb begin
    alu = '1;
    case (funct)
      F_ADDU: alu = a + b;
      F_SUBU: alu = a - b;
      F_AND:  alu = a & b;
      F_OR:   alu = a | b;
      F_XOR:  alu = a ^ b;
      F_NOR:  alu = ~(a | b);
      F_SLT:  alu = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      F_SLTU: alu = {{(W-1){1'b0}}, a < b};
      F_SLL:  alu = a << b[6+:SW];
      F_SRL:  alu = a >> b[6+:SW];
      F_SRA:  alu = $signed(a) >>> b[6+:SW];
      F_SLLV: alu = a << b[SW-1:0];
      F_SRLV: alu = a >> b[SW-1:0];
      F_SRAV: alu = $signed(a) >>> b[SW-1:0];
      F_MFHI: alu = hi;
      F_MFLO: alu = lo;
      F_MTHI, F_MTLO: alu = result;
      default: alu = '1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      result <= '0;
      hi <= '0;
      lo <= '0;
      neg_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
`endif
    end else begin
      state <= nxt;
      done <= (accept && !md_op) || state == FIX;
      if (accept && !md_op) begin
        result <= alu;
        if (funct == F_MTHI) hi <= a;
        if (funct == F_MTLO) lo <= a;
      end
      if (load) begin
        neg_q <= sa ^ sb;
`ifdef ALU_MULDIV_DIV_EN
        is_div <= funct[1];
        neg_r <= sa;
        dz <= b == '0;
`endif
      end
      if (state == FIX) begin
        hi <= hi_f;
        lo <= lo_f;
      end
    end
  end
  alu_md_iter #(.W(W)) u_iter (
    .clk(clk),
    .load(load),
    .step(state == CALC),
    .tc(SW'(W-1)),
    .x(xa),
    .y(yb),
    .acc(acc),
    .q(q),
    .last(last)
`ifdef ALU_MULDIV_DIV_EN
    , .div(funct[1])
`endif
  );
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv at W=32
module tb_alu_muldiv;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic reset, start, busy, done;
  logic [5:0] funct;
  logic [31:0] a, b, result, hi, lo;
  int n_chk = 0;
  int n_fail = 0;
  int n;
  logic seen;
  always #5 clk = ~clk;
  alu_muldiv #(.W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    funct = f;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic md(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] eh, input logic [31:0] el);
    op(f, x, y);
    chk({tag, "_busy"}, busy, 1);
    wait_done(n);
    chk({tag, "_lat"}, n, 34);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask
  task automatic sc(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] er);
    op(f, x, y);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res"}, result, er);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    funct = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    sc("addu", F_ADDU, 5, 7, 12);
    @(negedge clk);
    chk("addu_pulse", done, 0);
    sc("slt", F_SLT, 32'hFFFFFFFF, 1, 1);
    sc("sltu", F_SLTU, 32'hFFFFFFFF, 1, 0);
    sc("subu", F_SUBU, 3, 5, 32'hFFFFFFFE);
    sc("nor", F_NOR, 32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F);
    sc("sra", F_SRA, 32'h80000000, 32'h00000104, 32'hF8000000);
    sc("srl", F_SRL, 32'h80000000, 32'h00000104, 32'h08000000);
    sc("sllv", F_SLLV, 32'h00000003, 32'h00000104, 32'h00000030);
    sc("srav", F_SRAV, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF);
    sc("unk", 6'b111111, 1, 2, 32'hFFFFFFFF);
    md("mult", F_MULT, 32'hFFFFFFFD, 7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    chk("mult_res", result, 32'hFFFFFFFF);
    md("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
`ifdef ALU_MULDIV_DIV_EN
    md("div", F_DIV, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md("divu0", F_DIVU, 7, 0, 32'h00000007, 32'hFFFFFFFF);
    md("divov", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    md("divu", F_DIVU, 100, 7, 32'h00000002, 32'h0000000E);
`else
    sc("nodiv", F_DIV, 8, 2, 32'hFFFFFFFF);
    chk("nodiv_hi", hi, 32'hFFFFFFFE);
    chk("nodiv_lo", lo, 32'h00000001);
`endif
    op(F_MTHI, 32'h1234, 0);
    chk("mthi_done", done, 1);
    chk("mthi_hi", hi, 32'h1234);
    op(F_MFHI, 0, 0);
    chk("mfhi_done", done, 1);
    chk("mfhi_res", result, 32'h1234);
    op(F_MULT, 3, 5);
    chk("abort_busy", busy, 1);
    repeat (3) @(negedge clk);
    op(F_ADDU, 1, 1);
    chk("ign_res", result, 32'h1234);
    chk("ign_done", done, 0);
    chk("ign_busy", busy, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy0", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_res", result, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
